// File: rtl/pixmon_pkg.sv
// Shared types and helpers for the pixel stream monitor.
// Pure declarations: no timing, no state.
// Coordinates are carried at COORD_W bits internally so helpers work for any CW <= 16.
package pixmon_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int LIT_W   = 19;
    localparam int CHK_W   = 16;
    localparam int COORD_W = 16;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    // Rotate left by one bit.
    function automatic logic [CHK_W-1:0] rotl1(input logic [CHK_W-1:0] v);
        return {v[CHK_W-2:0], v[CHK_W-1]};
    endfunction

    // Raster successor: x wraps at x_last with y+1; y wraps at y_last back to the origin.
    function automatic coord_t next_coord(input coord_t c,
                                          input logic [COORD_W-1:0] x_last,
                                          input logic [COORD_W-1:0] y_last);
        coord_t n;
        n = c;
        if (c.x == x_last) begin
            n.x = '0;
            n.y = (c.y == y_last) ? '0 : c.y + 1'b1;
        end else begin
            n.x = c.x + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/pixmon_bbox_acc.sv
// Min/max bounding-box tracker for lit pixels within one frame.
// Latency: latch_i captures the box including the same-cycle update; outputs valid next cycle.
// No backpressure: one sample per cycle, always accepted.
module pixmon_bbox_acc #(
    parameter int CW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          upd_i,
    input  logic          latch_i,
    input  logic [CW-1:0] x_i,
    input  logic [CW-1:0] y_i,
    output logic [CW-1:0] x0_o,
    output logic [CW-1:0] x1_o,
    output logic [CW-1:0] y0_o,
    output logic [CW-1:0] y1_o,
    output logic          valid_o
);

    logic [CW-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic          any_q, any_d;

    // Next box: clear empties it (coords zeroed so an empty frame reports 0s), first lit pixel loads all four.
    always_comb begin
        x0_d  = x0_q;
        x1_d  = x1_q;
        y0_d  = y0_q;
        y1_d  = y1_q;
        any_d = any_q;
        if (clear_i) begin
            x0_d  = '0;
            x1_d  = '0;
            y0_d  = '0;
            y1_d  = '0;
            any_d = 1'b0;
        end
        if (upd_i) begin
            if (!any_d) begin
                x0_d = x_i;
                x1_d = x_i;
                y0_d = y_i;
                y1_d = y_i;
            end else begin
                if (x_i < x0_d) x0_d = x_i;
                if (x_i > x1_d) x1_d = x_i;
                if (y_i < y0_d) y0_d = y_i;
                if (y_i > y1_d) y1_d = y_i;
            end
            any_d = 1'b1;
        end
    end

    // Running box plus the published copy captured at frame end.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            any_q   <= 1'b0;
            x0_o    <= '0;
            x1_o    <= '0;
            y0_o    <= '0;
            y1_o    <= '0;
            valid_o <= 1'b0;
        end else begin
            x0_q  <= x0_d;
            x1_q  <= x1_d;
            y0_q  <= y0_d;
            y1_q  <= y1_d;
            any_q <= any_d;
            if (latch_i) begin
                x0_o    <= x0_d;
                x1_o    <= x1_d;
                y0_o    <= y0_d;
                y1_o    <= y1_d;
                valid_o <= any_d;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_monitor.sv
// Pixel stream sink: checks raster order, per-frame lit count / checksum / optional bbox (PIXMON_BBOX_EN).
// Latency: summary outputs and frame_done appear one cycle after the last pixel (H_ACTIVE-1,V_ACTIVE-1).
// No backpressure: every cycle carries one sample; sync errors are sticky until reset.
module pixel_stream_monitor
    import pixmon_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CW       = 10
) (
    input  logic             clk_pix,
    input  logic             sim_rst,
    input  logic [CW-1:0]    sdl_sx,
    input  logic [CW-1:0]    sdl_sy,
    input  logic             sdl_de,
    input  logic [7:0]       sdl_r,
    input  logic [7:0]       sdl_g,
    input  logic [7:0]       sdl_b,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic [LIT_W-1:0] lit_cnt,
    output logic [CHK_W-1:0] checksum,
    output logic [CW-1:0]    bbox_x0,
    output logic [CW-1:0]    bbox_x1,
    output logic [CW-1:0]    bbox_y0,
    output logic [CW-1:0]    bbox_y1,
    output logic             bbox_valid,
    output logic             sync_err
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    state_t            state_q, state_d;
    coord_t            cur;
    coord_t            exp_q, exp_d;
    logic [CHK_W-1:0]  chk_q, chk_d;
    logic [LIT_W-1:0]  acc_lit_q, acc_lit_d;
    logic              sync_err_q, sync_err_d;
    logic              is_origin, match, take, frame_end, lit_px;

    logic              frame_done_q;
    logic [15:0]       frame_cnt_q;
    logic [LIT_W-1:0]  lit_cnt_q;
    logic [CHK_W-1:0]  checksum_q;

    assign cur.x     = COORD_W'(sdl_sx);
    assign cur.y     = COORD_W'(sdl_sy);
    assign is_origin = (cur == '0);
    assign lit_px    = sdl_de && (|{sdl_r, sdl_g, sdl_b});

    // Raster tracking and frame accumulation; (0,0) always opens a fresh frame.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        sync_err_d = sync_err_q;
        chk_d      = chk_q;
        acc_lit_d  = acc_lit_q;
        frame_end  = 1'b0;

        match = (state_q == ACTIVE) && (cur == exp_q);
        take  = is_origin || match;

        // HUNT tolerates anything; only an out-of-order sample inside a frame is an error.
        if ((state_q == ACTIVE) && !match) begin
            sync_err_d = 1'b1;
        end

        if (take) begin
            state_d   = ACTIVE;
            exp_d     = next_coord(cur, X_LAST, Y_LAST);
            frame_end = (cur.x == X_LAST) && (cur.y == Y_LAST);
            if (is_origin) begin
                chk_d     = '0;
                acc_lit_d = '0;
            end
            if (sdl_de) begin
                chk_d = rotl1(chk_d) ^ {sdl_r ^ sdl_b, sdl_g};
            end
            if (lit_px) begin
                acc_lit_d = acc_lit_d + 1'b1;
            end
        end else if (state_q == ACTIVE) begin
            state_d = HUNT;
        end
    end

    // State, accumulators, and the summary registers published at frame end.
    always_ff @(posedge clk_pix or posedge sim_rst) begin
        if (sim_rst) begin
            state_q      <= HUNT;
            exp_q        <= '0;
            chk_q        <= '0;
            acc_lit_q    <= '0;
            sync_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            lit_cnt_q    <= '0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            chk_q        <= chk_d;
            acc_lit_q    <= acc_lit_d;
            sync_err_q   <= sync_err_d;
            frame_done_q <= frame_end;
            if (frame_end) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                lit_cnt_q   <= acc_lit_d;
                checksum_q  <= chk_d;
            end
        end
    end

    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign lit_cnt    = lit_cnt_q;
    assign checksum   = checksum_q;
    assign sync_err   = sync_err_q;

`ifdef PIXMON_BBOX_EN
    pixmon_bbox_acc #(.CW(CW)) u_bbox (
        .clk_i   (clk_pix),
        .rst_i   (sim_rst),
        .clear_i (is_origin),
        .upd_i   (take && lit_px),
        .latch_i (frame_end),
        .x_i     (sdl_sx),
        .y_i     (sdl_sy),
        .x0_o    (bbox_x0),
        .x1_o    (bbox_x1),
        .y0_o    (bbox_y0),
        .y1_o    (bbox_y1),
        .valid_o (bbox_valid)
    );
`else
    assign bbox_x0    = '0;
    assign bbox_x1    = '0;
    assign bbox_y0    = '0;
    assign bbox_y1    = '0;
    assign bbox_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_stream_monitor.sv
// Bench for pixel_stream_monitor on a reduced raster (12x8) so whole frames stay short.
// Frames are painted into a frame buffer; expected summaries come from scanning that buffer.
// Bbox expectations follow PIXMON_BBOX_EN (zeros when the feature is not built).
module tb_pixel_stream_monitor;

    localparam int H    = 12;
    localparam int V    = 8;
    localparam int CW   = 10;
    localparam int NPIX = H * V;

    logic          clk_pix = 1'b0;
    logic          sim_rst;
    logic [CW-1:0] sdl_sx, sdl_sy;
    logic          sdl_de;
    logic [7:0]    sdl_r, sdl_g, sdl_b;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic [18:0]   lit_cnt;
    logic [15:0]   checksum;
    logic [CW-1:0] bbox_x0, bbox_x1, bbox_y0, bbox_y1;
    logic          bbox_valid;
    logic          sync_err;

    always #5 clk_pix = ~clk_pix;

    pixel_stream_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .CW(CW)) dut (
        .clk_pix    (clk_pix),
        .sim_rst    (sim_rst),
        .sdl_sx     (sdl_sx),
        .sdl_sy     (sdl_sy),
        .sdl_de     (sdl_de),
        .sdl_r      (sdl_r),
        .sdl_g      (sdl_g),
        .sdl_b      (sdl_b),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .lit_cnt    (lit_cnt),
        .checksum   (checksum),
        .bbox_x0    (bbox_x0),
        .bbox_x1    (bbox_x1),
        .bbox_y0    (bbox_y0),
        .bbox_y1    (bbox_y1),
        .bbox_valid (bbox_valid),
        .sync_err   (sync_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic       fb_de [V][H];
    logic [7:0] fb_r  [V][H];
    logic [7:0] fb_g  [V][H];
    logic [7:0] fb_b  [V][H];

    // Reference summary of the last good frame.
    int   m_lit, m_chk, m_x0, m_x1, m_y0, m_y1, m_fcnt;
    bit   m_bv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void clear_fb();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                fb_de[y][x] = 1'b0;
                fb_r[y][x]  = 8'h00;
                fb_g[y][x]  = 8'h00;
                fb_b[y][x]  = 8'h00;
            end
    endfunction

    function automatic void random_fb();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                fb_de[y][x] = ($urandom_range(0, 1) == 1);
                fb_r[y][x]  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                fb_g[y][x]  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                fb_b[y][x]  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            end
    endfunction

    // Scan the frame buffer in raster order and derive the expected summary.
    function automatic void model_frame();
        int c;
        c    = 0;
        m_lit = 0;
        m_x0 = H; m_x1 = -1; m_y0 = V; m_y1 = -1;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                if (fb_de[y][x]) begin
                    c = ((c * 2) + (c / 32768)) % 65536;
                    c = c ^ ((int'(fb_r[y][x] ^ fb_b[y][x]) * 256) + int'(fb_g[y][x]));
                    if ((fb_r[y][x] != 0) || (fb_g[y][x] != 0) || (fb_b[y][x] != 0)) begin
                        m_lit++;
                        if (x < m_x0) m_x0 = x;
                        if (x > m_x1) m_x1 = x;
                        if (y < m_y0) m_y0 = y;
                        if (y > m_y1) m_y1 = y;
                    end
                end
        m_chk = c;
        m_bv  = (m_lit > 0);
        if (!m_bv) begin
            m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
        end
    endfunction

    task automatic step(input int x, input int y, input logic de,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        sdl_sx = CW'(x);
        sdl_sy = CW'(y);
        sdl_de = de;
        sdl_r  = r;
        sdl_g  = g;
        sdl_b  = b;
        @(posedge clk_pix);
        #1;
    endtask

    // Drive raster indices first..last from the frame buffer, optionally skipping one index.
    task automatic run_span(input int first, input int last, input int skip,
                            output int n_done, output bit done_at_end);
        n_done      = 0;
        done_at_end = 1'b0;
        for (int i = first; i <= last; i++) begin
            if (i == skip) continue;
            step(i % H, i / H, fb_de[i / H][i % H], fb_r[i / H][i % H],
                 fb_g[i / H][i % H], fb_b[i / H][i % H]);
            if (frame_done === 1'b1) begin
                n_done++;
                if (i == NPIX - 1) done_at_end = 1'b1;
            end
        end
    endtask

    task automatic check_summary(input string tag);
        chk({tag, ".lit"},   64'(lit_cnt),   64'(m_lit));
        chk({tag, ".chk"},   64'(checksum),  64'(m_chk));
        chk({tag, ".fcnt"},  64'(frame_cnt), 64'(m_fcnt));
`ifdef PIXMON_BBOX_EN
        chk({tag, ".bbox"},  {bbox_valid, 16'(bbox_x0), 16'(bbox_x1), 16'(bbox_y0), 16'(bbox_y1)},
                             {m_bv, 16'(m_x0), 16'(m_x1), 16'(m_y0), 16'(m_y1)});
`else
        chk({tag, ".bbox"},  {bbox_valid, 16'(bbox_x0), 16'(bbox_x1), 16'(bbox_y0), 16'(bbox_y1)}, 64'd0);
`endif
    endtask

    // One complete good frame: exactly one frame_done, on the cycle after the last pixel.
    task automatic good_frame(input string tag);
        int n_done;
        bit at_end;
        model_frame();
        run_span(0, NPIX - 1, -1, n_done, at_end);
        m_fcnt++;
        chk({tag, ".ndone"}, 64'(n_done), 64'd1);
        chk({tag, ".done_end"}, 64'(at_end), 64'd1);
        check_summary(tag);
    endtask

    initial begin
        int  n_done;
        bit  at_end;
        int  mid;

        sim_rst = 1'b1;
        sdl_sx = '0; sdl_sy = '0; sdl_de = 1'b0;
        sdl_r = 8'h00; sdl_g = 8'h00; sdl_b = 8'h00;
        m_fcnt = 0;
        repeat (3) @(posedge clk_pix);
        #1;
        chk("reset.outputs", 64'(|{frame_done, frame_cnt, lit_cnt, checksum, bbox_x0, bbox_x1,
                                     bbox_y0, bbox_y1, bbox_valid, sync_err}), 64'd0);
        sim_rst = 1'b0;

        // Red square in the bottom-left corner, de only inside the square.
        clear_fb();
        for (int y = V - 4; y < V; y++)
            for (int x = 0; x < 4; x++) begin
                fb_de[y][x] = 1'b1;
                fb_r[y][x]  = 8'hFF;
            end
        good_frame("square");
        chk("square.lit_const", 64'(lit_cnt), 64'd16);
        chk("square.fcnt_const", 64'(frame_cnt), 64'd1);

        // de everywhere, all black.
        clear_fb();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) fb_de[y][x] = 1'b1;
        good_frame("black");
        chk("black.chk_const", 64'(checksum), 64'h0);
        chk("black.bv_const", 64'(bbox_valid), 64'd0);

        // Single pixel at the origin.
        clear_fb();
        fb_de[0][0] = 1'b1; fb_r[0][0] = 8'h12; fb_g[0][0] = 8'h34; fb_b[0][0] = 8'h56;
        good_frame("origin");
        chk("origin.chk_const", 64'(checksum), 64'h4434);

        for (int k = 0; k < 3; k++) begin
            random_fb();
            good_frame($sformatf("rand%0d", k));
        end
        chk("rand.sync_err", 64'(sync_err), 64'd0);

        // Asynchronous reset mid-frame clears everything within the same cycle.
        random_fb();
        mid = (V / 2) * H + H / 2;
        run_span(0, mid - 1, -1, n_done, at_end);
        sdl_sx = CW'(H / 2); sdl_sy = CW'(V / 2);
        #2;
        sim_rst = 1'b1;
        #1;
        chk("midrst.outputs", 64'(|{frame_done, frame_cnt, lit_cnt, checksum, bbox_x0, bbox_x1,
                                     bbox_y0, bbox_y1, bbox_valid, sync_err}), 64'd0);
        @(posedge clk_pix);
        #1;
        sim_rst = 1'b0;
        m_fcnt = 0;
        run_span(mid + 1, NPIX - 1, -1, n_done, at_end);
        chk("midrst.tail_ndone", 64'(n_done), 64'd0);
        chk("midrst.sync_err", 64'(sync_err), 64'd0);
        random_fb();
        good_frame("after_rst");

        // Coordinate skip inside line 5: frame is discarded, outputs held.
        random_fb();
        run_span(0, NPIX - 1, 5 * H + 5, n_done, at_end);
        chk("glitch.ndone", 64'(n_done), 64'd0);
        chk("glitch.sync_err", 64'(sync_err), 64'd1);
        check_summary("glitch.held");
        random_fb();
        good_frame("post_glitch");
        chk("post_glitch.sync_err", 64'(sync_err), 64'd1);

        // Stream joins mid-frame after reset; only the following full frame counts.
        sim_rst = 1'b1;
        @(posedge clk_pix);
        #1;
        sim_rst = 1'b0;
        m_fcnt = 0;
        random_fb();
        run_span((V / 2) * H + H / 2, NPIX - 1, -1, n_done, at_end);
        chk("join.ndone", 64'(n_done), 64'd0);
        clear_fb();
        fb_de[V - 1][H - 1] = 1'b1; fb_g[V - 1][H - 1] = 8'h80;
        good_frame("join");
        chk("join.sync_err", 64'(sync_err), 64'd0);
        chk("join.lit_const", 64'(lit_cnt), 64'd1);
`ifdef PIXMON_BBOX_EN
        chk("join.bbox_const", {16'(bbox_x0), 16'(bbox_x1), 16'(bbox_y0), 16'(bbox_y1)},
            {16'(H - 1), 16'(H - 1), 16'(V - 1), 16'(V - 1)});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
